// File: rtl/slp_pkg.sv
// Shared types, default widths and the rescale/saturate helper for the
// streaming single-layer-perceptron classifier.
package slp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_ARGMAX,
        S_OUT
    } state_e;

    localparam int NUM_FEATURES_DEF = 95;
    localparam int NUM_CLASSES_DEF  = 6;
    localparam int X_W_DEF          = 16;
    localparam int W_W_DEF          = 16;
    localparam int ACC_W_DEF        = 40;
    localparam int SCORE_W_DEF      = 32;
    localparam int SHIFT_DEF        = 0;

    // Arithmetic shift then clamp into the signed score_w range; the caller
    // keeps the low score_w bits of the result.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int score_w);
        logic signed [63:0] shifted;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        shifted = acc >>> shift;
        maxV    = (64'sd1 <<< (score_w - 1)) - 64'sd1;
        minV    = -(64'sd1 <<< (score_w - 1));
        if (shifted > maxV) begin
            return maxV;
        end
        if (shifted < minV) begin
            return minV;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/slp_stream_classifier_mac_lane.sv
// One class lane: weight row plus bias (bias lives at index NUM_FEATURES of
// the row memory), the running accumulator and the registered saturated score.
module slp_mac_lane
    import slp_pkg::*;
#(
    parameter int NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int X_W          = X_W_DEF,
    parameter int W_W          = W_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int SHIFT        = SHIFT_DEF,
    parameter int FW           = $clog2(NUM_FEATURES + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      wr_en_i,
    input  logic [FW-1:0]             wr_feat_i,
    input  logic signed [W_W-1:0]     wr_data_i,
    input  logic                      mac_en_i,
    input  logic [FW-1:0]             feat_i,
    input  logic signed [X_W-1:0]     x_i,
    input  logic                      bias_en_i,
    input  logic                      zero_i,
    output logic signed [SCORE_W-1:0] score_o
);

    localparam logic [FW-1:0] BIAS_IDX = FW'(NUM_FEATURES);

    logic signed [W_W-1:0]         mem_q [2**FW];
    logic signed [X_W+W_W-1:0]     prod;
    logic signed [ACC_W-1:0]       acc_q;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [SCORE_W-1:0]     score_q;
    logic signed [SCORE_W-1:0]     score_d;
    logic signed [63:0]            biased;

    // Coefficient memory deliberately has no reset so it survives rst and clear.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_feat_i] <= wr_data_i;
        end
    end

    always_comb begin
        prod   = x_i * mem_q[feat_i];
        biased = 64'(acc_q) + 64'(mem_q[BIAS_IDX]);
        acc_d  = acc_q;
        if (clear_i || zero_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        score_d = score_q;
        if (clear_i) begin
            score_d = '0;
        end else if (bias_en_i) begin
            score_d = SCORE_W'(sat_shift(biased, SHIFT, SCORE_W));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            score_q <= '0;
        end else begin
            acc_q   <= acc_d;
            score_q <= score_d;
        end
    end

    assign score_o = score_q;

endmodule

// File: rtl/slp_stream_classifier.sv
// Streaming perceptron classifier top: frame FSM, feature counter, sequential
// argmax with threshold rejection, sticky error flags and the MAC lane array.
module slp_stream_classifier
    import slp_pkg::*;
#(
    parameter int NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int NUM_CLASSES  = NUM_CLASSES_DEF,
    parameter int X_W          = X_W_DEF,
    parameter int W_W          = W_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int SHIFT        = SHIFT_DEF,
    parameter int CW           = $clog2(NUM_CLASSES),
    parameter int FW           = $clog2(NUM_FEATURES + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              w_wr_en_i,
    input  logic [CW-1:0]                     w_wr_class_i,
    input  logic [FW-1:0]                     w_wr_feat_i,
    input  logic signed [W_W-1:0]             w_wr_data_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic signed [X_W-1:0]             in_data_i,
    input  logic                              in_last_i,
    input  logic signed [SCORE_W-1:0]         thresh_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [3:0]                        out_class_o,
    output logic signed [SCORE_W-1:0]         out_score_o,
    output logic                              out_reject_o,
    output logic [NUM_CLASSES*SCORE_W-1:0]    scores_o,
    output logic                              busy_o,
    output logic [1:0]                        err_o
);

    state_e                    state_q, state_d;
    logic [FW-1:0]             cnt_q, cnt_d;
    logic [CW-1:0]             argIdx_q, argIdx_d;
    logic [CW-1:0]             bestIdx_q, bestIdx_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic signed [SCORE_W-1:0] thresh_q, thresh_d;
    logic                      out_valid_q, out_valid_d;
    logic [3:0]                out_class_q, out_class_d;
    logic signed [SCORE_W-1:0] out_score_q, out_score_d;
    logic                      out_reject_q, out_reject_d;
    logic [1:0]                err_q, err_d;
    logic signed [SCORE_W-1:0] laneScore [NUM_CLASSES];

    logic inHs, outHs, cntLast, frameEnd, lenErr, argLast;
    logic wrRange, wrDrop, wrOk;

    assign in_ready_o = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign busy_o     = (state_q != S_IDLE);
    assign inHs       = in_valid_i && in_ready_o;
    assign outHs      = (state_q == S_OUT) && out_valid_q && out_ready_i;
    assign cntLast    = (32'(cnt_q) == NUM_FEATURES - 1);
    assign frameEnd   = inHs && (cntLast || in_last_i);
    assign lenErr     = inHs && (cntLast != in_last_i);
    assign argLast    = (32'(argIdx_q) == NUM_CLASSES - 1);

    // A write on the frame's final beat is dropped too: busy rises on that edge.
    assign wrRange = (32'(w_wr_class_i) < NUM_CLASSES) && (32'(w_wr_feat_i) <= NUM_FEATURES);
    assign wrDrop  = w_wr_en_i && (busy_o || frameEnd || !wrRange);
    assign wrOk    = w_wr_en_i && !wrDrop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (inHs) state_d = frameEnd ? S_BIAS : S_ACCUM;
            S_ACCUM:  if (frameEnd) state_d = S_BIAS;
            S_BIAS:   state_d = S_ARGMAX;
            S_ARGMAX: if (argLast) state_d = S_OUT;
            S_OUT:    if (outHs) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
        end
    end

    // OUT spends one cycle registering the winner before out_valid rises.
    always_comb begin
        cnt_d        = cnt_q;
        argIdx_d     = argIdx_q;
        bestIdx_d    = bestIdx_q;
        best_d       = best_q;
        thresh_d     = thresh_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        out_reject_d = out_reject_q;
        err_d        = err_q | {wrDrop, lenErr};

        if (inHs) begin
            cnt_d = cnt_q + FW'(1);
        end
        if (state_q == S_BIAS) begin
            thresh_d = thresh_i;
        end
        if (state_q == S_ARGMAX) begin
            if ((argIdx_q == '0) || (laneScore[argIdx_q] > best_q)) begin
                best_d    = laneScore[argIdx_q];
                bestIdx_d = argIdx_q;
            end
            argIdx_d = argLast ? '0 : argIdx_q + CW'(1);
        end
        if (state_q == S_OUT) begin
            if (!out_valid_q) begin
                out_valid_d  = 1'b1;
                out_class_d  = 4'(bestIdx_q);
                out_score_d  = best_q;
                out_reject_d = (best_q < thresh_q);
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
            end
        end
        if (clear_i) begin
            cnt_d        = '0;
            argIdx_d     = '0;
            bestIdx_d    = '0;
            best_d       = '0;
            out_valid_d  = 1'b0;
            out_class_d  = '0;
            out_score_d  = '0;
            out_reject_d = 1'b0;
            err_d        = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            argIdx_q     <= '0;
            bestIdx_q    <= '0;
            best_q       <= '0;
            thresh_q     <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_reject_q <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            argIdx_q     <= argIdx_d;
            bestIdx_q    <= bestIdx_d;
            best_q       <= best_d;
            thresh_q     <= thresh_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            out_reject_q <= out_reject_d;
            err_q        <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : gLane
        slp_mac_lane #(
            .NUM_FEATURES (NUM_FEATURES),
            .X_W          (X_W),
            .W_W          (W_W),
            .ACC_W        (ACC_W),
            .SCORE_W      (SCORE_W),
            .SHIFT        (SHIFT),
            .FW           (FW)
        ) uLane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clear_i   (clear_i),
            .wr_en_i   (wrOk && (w_wr_class_i == CW'(k))),
            .wr_feat_i (w_wr_feat_i),
            .wr_data_i (w_wr_data_i),
            .mac_en_i  (inHs && !clear_i),
            .feat_i    (cnt_q),
            .x_i       (in_data_i),
            .bias_en_i (state_q == S_BIAS),
            .zero_i    (outHs),
            .score_o   (laneScore[k])
        );
        assign scores_o[k*SCORE_W +: SCORE_W] = laneScore[k];
    end

    assign out_valid_o  = out_valid_q;
    assign out_class_o  = out_class_q;
    assign out_score_o  = out_score_q;
    assign out_reject_o = out_reject_q;
    assign err_o        = err_q;

endmodule

// File: doc/slp_stream_classifier.md
# slp_stream_classifier

Streaming single-layer-perceptron classifier engine for the HAR inference path, succeeding the fixed-size array-in classifier. Feature samples arrive one per beat over a valid/ready stream and drive NUM_CLASSES parallel multiply-accumulate lanes against on-chip weights and biases. Each lane's result is rescaled and saturated. A time-multiplexed argmax then selects the winner, with a programmable confidence threshold for rejection. The result is presented on a held valid/ready output.

## Interface
- NUM_FEATURES, 95: features per frame.
- NUM_CLASSES, 6: output classes and MAC lanes.
- X_W, 16: signed feature width.
- W_W, 16: signed weight and bias width.
- ACC_W, 40: signed accumulator width.
- SCORE_W, 32: signed score width.
- SHIFT, 0: arithmetic right shift applied after the bias add.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear. It aborts the current frame and preserves weights.
- w_wr_en  in  1  weight/bias write strobe.
- w_wr_class  in  $clog2(NUM_CLASSES)  target class.
- w_wr_feat  in  $clog2(NUM_FEATURES+1)  feature index; the value NUM_FEATURES selects the bias.
- w_wr_data  in  W_W  signed write data.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  engine accepts a beat.
- in_data  in  X_W  signed feature.
- in_last  in  1  marks the final beat of a frame.
- thresh  in  SCORE_W  signed rejection threshold, sampled in BIAS.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_class  out  4  winning class index.
- out_score  out  SCORE_W  winning score.
- out_reject  out  1  winning score is below the threshold.
- scores  out  NUM_CLASSES*SCORE_W  all class scores; class k occupies bits [k*SCORE_W +: SCORE_W].
- busy  out  1  a frame is in flight (ACCUM after the first beat, BIAS, ARGMAX, OUT).
- err  out  2  sticky error flags: bit0 = length error, bit1 = write dropped. Cleared only by rst or clear.

## Operation
- **FSM states:** IDLE, ACCUM, BIAS, ARGMAX, OUT.
- **IDLE/ACCUM:**
  - in_ready = 1.
  - On each handshake, lane k adds in_data × W[k][cnt] (X_W+W_W-bit signed product, sign-extended to ACC_W), then cnt increments.
  - The first beat moves IDLE to ACCUM.
- **End of frame:**
  - The frame ends on the beat where cnt == NUM_FEATURES-1, or on an in_last beat, whichever comes first.
  - An early in_last sets err[0]; the missing features contribute zero.
  - A final beat without in_last also sets err[0].
  - Either way the FSM moves to BIAS.
- **BIAS (1 cycle):**
  - Per lane, compute (acc + sign-extended bias) >>> SHIFT.
  - Saturate to the signed SCORE_W range and register the result into scores.
  - Latch thresh.
- **ARGMAX (NUM_CLASSES cycles):**
  - Cycle i compares scores[i] against the running best; a strictly greater score replaces it.
  - Ties therefore go to the lowest index. Class 0 seeds the best on cycle 0.
- **OUT:**
  - out_valid = 1.
  - out_class and out_score are the winner; out_reject = (best < thresh), signed comparison.
  - All outputs are held stable until out_ready.
  - On the handshake: accumulators and cnt are zeroed, and the FSM returns to IDLE.
  - scores keep their values until the next BIAS.
- **in_ready** is 0 in BIAS, ARGMAX and OUT; in_valid in those states is ignored.
- **Weight writes:** accepted only when busy = 0. When busy = 1 the write is dropped and err[1] is set. Out-of-range class or feature indices are dropped and set err[1].
- **clear:** beats rst-free logic in priority. It zeroes accumulators, cnt, the out_* outputs, scores and err, and moves the FSM to IDLE. The weight and bias memory is untouched.

## Timing
- **After rst:**
  - FSM in IDLE, in_ready = 1.
  - out_valid, out_class, out_score, out_reject, scores, busy and err are all 0.
  - Weight and bias memory is not reset.
- **Throughput:** one feature per cycle.
- **Latency:** out_valid rises NUM_CLASSES+2 rising edges after the edge that accepts the final beat.
- **Frame period:** at minimum NUM_FEATURES + NUM_CLASSES + 3 cycles, with out_ready held high.
- **Weight write during the final-beat cycle:** the write is dropped, because busy is already 1 (or becomes 1 on that edge).
- **clear and a handshake in the same cycle:** clear wins and the beat is discarded.

## Structure
- **Shared package slp_pkg:**
  - state enum;
  - default width constants;
  - a `sat_shift(acc, shift)` function for the rescale and saturation.
- **Sub-module slp_mac_lane:**
  - one instance per class;
  - contains the weight row, bias register, accumulator and BIAS-stage rescale/saturation.
- **Top level:** FSM, feature counter, argmax sequencer, error flags.

## Test plan
All scenarios use NUM_FEATURES=4, NUM_CLASSES=3, SHIFT=0.
1. **Reset:** assert rst low mid-frame → in_ready=1, out_valid=0, scores=0 and err=0 immediately, with no wait for clk.
2. **Basic frame:**
   - Setup: W[k][*]=k+1, biases 0, x=1,2,3,4 with in_last on beat 4.
   - Required: scores=10,20,30, out_class=2, out_score=30, and out_valid exactly 5 edges after the last beat.
3. **Bias, tie and reject:**
   - Setup: all weights 1, bias={5,5,-1}, thresh=100, x=1,1,1,1.
   - Required: scores=9,9,3, out_class=0, out_reject=1.
4. **Saturation:**
   - Setup: x=32767 and W=32767 everywhere, bias 0.
   - Required: every score = 2147483647. Repeat with W=-32768 → every score = -2147483648.
5. **Length errors:** in_last on beat 2 → the frame ends after 2 beats and err[0]=1. A weight write while busy → err[1]=1 and the memory is unchanged on re-read.
6. **Backpressure and clear:** hold out_ready=0 for 10 cycles → out_valid and out_class stay stable and in_ready=0. Pulse clear after 2 accepted beats → IDLE, and the next full frame yields the scenario-2 result.
